// File: rtl/crypto_bus_arbiter.sv
// crypto_bus_arbiter: two-master round-robin arbiter for the crypto MMIO bus.
// One transaction in flight at a time; a slave that never answers is
// converted into an error response after TIMEOUT_CYCLES so no master hangs.
module crypto_bus_arbiter #(
    parameter int          TIMEOUT_CYCLES = 256,
    parameter int          CNT_W          = 9,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_we,
    input  logic        m0_valid,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_we,
    input  logic        m1_valid,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic        s_we,
    output logic        s_valid,
    input  logic [31:0] s_rdata,
    input  logic        s_ready,
    output logic        err,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_t;

    state_t            r_state, w_next;
    logic              r_last_grant;   // master that won the previous grant
    logic              r_gnt;          // master owning the transaction in flight
    logic [CNT_W-1:0]  r_cnt;
    logic              r_timeout;
    logic [31:0]       r_s_addr, r_s_wdata;
    logic              r_s_we, r_s_valid;
    logic [1:0][31:0]  r_rdata;
    logic [7:0]        r_err_cnt;

    logic              w_any_req;
    logic              w_gnt;
    logic              w_cnt_done;

    assign w_any_req  = m0_valid | m1_valid;
    // On a tie the master that did not win last time goes first.
    assign w_gnt      = (m0_valid & m1_valid) ? ~r_last_grant : m1_valid;
    assign w_cnt_done = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic; s_ready outside ISSUE is deliberately ignored.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_any_req) w_next = ST_ISSUE;
            ST_ISSUE: if (s_ready || w_cnt_done) w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Grant capture, slave request registers and timeout counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= 1'b1;
            r_gnt        <= 1'b0;
            r_cnt        <= '0;
            r_timeout    <= 1'b0;
            r_s_addr     <= '0;
            r_s_wdata    <= '0;
            r_s_we       <= 1'b0;
            r_s_valid    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_any_req) begin
                    r_gnt        <= w_gnt;
                    r_last_grant <= w_gnt;
                    r_s_addr     <= w_gnt ? m1_addr  : m0_addr;
                    r_s_wdata    <= w_gnt ? m1_wdata : m0_wdata;
                    r_s_we       <= w_gnt ? m1_we    : m0_we;
                    r_s_valid    <= 1'b1;
                    r_cnt        <= '0;
                    r_timeout    <= 1'b0;
                end
                ST_ISSUE: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A slave answer in the last allowed cycle beats the timeout.
                    if (s_ready) begin
                        r_s_valid <= 1'b0;
                    end else if (w_cnt_done) begin
                        r_s_valid <= 1'b0;
                        r_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-master read data; each holds until that master's next completion.
    for (genvar g = 0; g < 2; g++) begin : g_rdata
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_rdata[g] <= '0;
            end else if (r_state == ST_ISSUE && r_gnt == g[0]) begin
                if (s_ready)         r_rdata[g] <= s_rdata;
                else if (w_cnt_done) r_rdata[g] <= ERR_DATA;
            end
        end
    end

    // Saturating timeout counter, bumped in the response cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_err_cnt <= '0;
        else if (r_state == ST_RESP && r_timeout && r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign s_addr   = r_s_addr;
    assign s_wdata  = r_s_wdata;
    assign s_we     = r_s_we;
    assign s_valid  = r_s_valid;
    assign m0_rdata = r_rdata[0];
    assign m1_rdata = r_rdata[1];
    assign m0_ready = (r_state == ST_RESP) && !r_gnt;
    assign m1_ready = (r_state == ST_RESP) &&  r_gnt;
    assign err      = (r_state == ST_RESP) && r_timeout;
    assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_crypto_bus_arbiter.sv
// tb_crypto_bus_arbiter: directed scenarios for the two-master crypto bus arbiter.
module tb_crypto_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_we, m0_valid, m1_we, m1_valid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ready, m1_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        s_we, s_valid, s_ready;
    logic        err;
    logic [7:0]  err_cnt;

    int errors = 0;
    int checks = 0;

    crypto_bus_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(5), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_valid(m0_valid),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_valid(m1_valid),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_valid(s_valid),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m0_addr = '0; m0_wdata = '0; m0_we = 1'b0; m0_valid = 1'b0;
        m1_addr = '0; m1_wdata = '0; m1_we = 1'b0; m1_valid = 1'b0;
        s_rdata = '0; s_ready = 1'b0;
        tick(); tick();
        checks++;
        if ({s_valid, s_we, m0_ready, m1_ready, err} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b want=00000", {s_valid, s_we, m0_ready, m1_ready, err});
        end
        checks++;
        if (s_addr !== 32'h0 || s_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_sbus got addr=%h wdata=%h want 0", s_addr, s_wdata);
        end
        checks++;
        if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0 || err_cnt !== 8'h0) begin
            errors++; $display("FAIL reset_rdata got %h %h cnt=%0d want 0", m0_rdata, m1_rdata, err_cnt);
        end
        rst = 1'b1;
        tick();
    endtask

    // m0 read, slave answers in the cycle after s_valid rises.
    task automatic test_single_read();
        m0_addr = 32'h4000_4004; m0_we = 1'b0; m0_valid = 1'b1;     // cycle 0
        tick();                                                      // cycle 1
        checks++;
        if (s_valid !== 1'b1 || s_addr !== 32'h4000_4004 || s_we !== 1'b0) begin
            errors++; $display("FAIL read_issue got v=%b addr=%h we=%b want 1 40004004 0", s_valid, s_addr, s_we);
        end
        tick();                                                      // cycle 2
        checks++;
        if (s_valid !== 1'b1 || m0_ready !== 1'b0) begin
            errors++; $display("FAIL read_hold got v=%b rdy=%b want 1 0", s_valid, m0_ready);
        end
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        tick();                                                      // cycle 3
        s_ready = 1'b0;
        checks++;
        if (m0_ready !== 1'b1 || m1_ready !== 1'b0 || s_valid !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL read_done got m0r=%b m1r=%b sv=%b err=%b want 1 0 0 0", m0_ready, m1_ready, s_valid, err);
        end
        checks++;
        if (m0_rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL read_data got=%h want=12345678", m0_rdata);
        end
        m0_valid = 1'b0;
        tick();                                                      // cycle 4
        checks++;
        if (m0_ready !== 1'b0 || m0_rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL read_retain got rdy=%b data=%h want 0 12345678", m0_ready, m0_rdata);
        end
    endtask

    // Simultaneous writes after reset; m0 stays valid back-to-back, so m1 then m0.
    task automatic test_tie_round_robin();
        rst = 1'b0; tick(); rst = 1'b1;
        m0_addr = 32'h4000_4000; m0_wdata = 32'hAAAA_0000; m0_we = 1'b1; m0_valid = 1'b1;
        m1_addr = 32'h4000_4008; m1_wdata = 32'hBBBB_0001; m1_we = 1'b1; m1_valid = 1'b1;
        tick();                                                      // ISSUE
        checks++;
        if (s_addr !== 32'h4000_4000 || s_wdata !== 32'hAAAA_0000 || s_we !== 1'b1) begin
            errors++; $display("FAIL tie_first got addr=%h wdata=%h we=%b want 40004000 aaaa0000 1", s_addr, s_wdata, s_we);
        end
        s_ready = 1'b1; s_rdata = 32'h0000_0011;
        tick();                                                      // RESP
        s_ready = 1'b0;
        checks++;
        if (m0_ready !== 1'b1 || m1_ready !== 1'b0 || m0_rdata !== 32'h0000_0011) begin
            errors++; $display("FAIL tie_first_done got m0r=%b m1r=%b d=%h want 1 0 00000011", m0_ready, m1_ready, m0_rdata);
        end
        m0_addr = 32'h4000_4010; m0_wdata = 32'hCCCC_0002;
        tick();                                                      // IDLE
        tick();                                                      // ISSUE
        checks++;
        if (s_addr !== 32'h4000_4008 || s_wdata !== 32'hBBBB_0001) begin
            errors++; $display("FAIL tie_second got addr=%h wdata=%h want 40004008 bbbb0001", s_addr, s_wdata);
        end
        s_ready = 1'b1; s_rdata = 32'h0000_0022;
        tick();
        s_ready = 1'b0;
        checks++;
        if (m1_ready !== 1'b1 || m0_ready !== 1'b0 || m1_rdata !== 32'h0000_0022) begin
            errors++; $display("FAIL tie_second_done got m1r=%b m0r=%b d=%h want 1 0 00000022", m1_ready, m0_ready, m1_rdata);
        end
        m1_valid = 1'b0;
        tick(); tick();
        checks++;
        if (s_addr !== 32'h4000_4010 || s_wdata !== 32'hCCCC_0002) begin
            errors++; $display("FAIL tie_third got addr=%h wdata=%h want 40004010 cccc0002", s_addr, s_wdata);
        end
        s_ready = 1'b1; s_rdata = 32'h0000_0033;
        tick();
        s_ready = 1'b0;
        checks++;
        if (m0_ready !== 1'b1 || m0_rdata !== 32'h0000_0033) begin
            errors++; $display("FAIL tie_third_done got rdy=%b d=%h want 1 00000033", m0_ready, m0_rdata);
        end
        m0_valid = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
        tick();
    endtask

    // m1 arrives while m0 is in flight; bus stays on m0 until completion.
    task automatic test_no_preempt();
        m0_addr = 32'h4000_0100; m0_valid = 1'b1;
        tick();
        m1_addr = 32'h4000_1200; m1_valid = 1'b1;
        tick();
        tick();
        checks++;
        if (s_addr !== 32'h4000_0100 || s_valid !== 1'b1 || m1_ready !== 1'b0) begin
            errors++; $display("FAIL hold_addr got addr=%h v=%b m1r=%b want 40000100 1 0", s_addr, s_valid, m1_ready);
        end
        s_ready = 1'b1; s_rdata = 32'h0000_00A5;
        tick();
        s_ready = 1'b0;
        checks++;
        if (m0_ready !== 1'b1 || m1_ready !== 1'b0 || m0_rdata !== 32'h0000_00A5) begin
            errors++; $display("FAIL hold_m0_done got m0r=%b m1r=%b d=%h want 1 0 000000a5", m0_ready, m1_ready, m0_rdata);
        end
        m0_valid = 1'b0;
        tick(); tick();
        checks++;
        if (s_addr !== 32'h4000_1200 || s_valid !== 1'b1) begin
            errors++; $display("FAIL hold_m1_grant got addr=%h v=%b want 40001200 1", s_addr, s_valid);
        end
        s_ready = 1'b1; s_rdata = 32'h0000_005A;
        tick();
        s_ready = 1'b0;
        checks++;
        if (m1_ready !== 1'b1 || m1_rdata !== 32'h0000_005A || m0_rdata !== 32'h0000_00A5) begin
            errors++; $display("FAIL hold_m1_done got rdy=%b d1=%h d0=%h want 1 0000005a 000000a5", m1_ready, m1_rdata, m0_rdata);
        end
        m1_valid = 1'b0;
        tick();
    endtask

    // Silent slave: ready 16 cycles after s_valid rose, error data, err pulse.
    task automatic test_timeout();
        logic early = 1'b0;
        m0_addr = 32'h4000_2000; m0_valid = 1'b1;                    // cycle 0
        tick();                                                      // cycle 1
        for (int c = 2; c <= 16; c++) begin
            tick();
            if (m0_ready !== 1'b0 || s_valid !== 1'b1) early = 1'b1;
        end
        checks++;
        if (early) begin
            errors++; $display("FAIL tmo_early got early completion or s_valid drop before cycle 17");
        end
        tick();                                                      // cycle 17
        checks++;
        if (m0_ready !== 1'b1 || err !== 1'b1 || m1_ready !== 1'b0 || s_valid !== 1'b0) begin
            errors++; $display("FAIL tmo_done got rdy=%b err=%b m1r=%b sv=%b want 1 1 0 0", m0_ready, err, m1_ready, s_valid);
        end
        checks++;
        if (m0_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL tmo_data got=%h want=deadbeef", m0_rdata);
        end
        m0_valid = 1'b0;
        tick();                                                      // cycle 18
        checks++;
        if (err !== 1'b0 || err_cnt !== 8'd1) begin
            errors++; $display("FAIL tmo_cnt got err=%b cnt=%0d want 0 1", err, err_cnt);
        end
        s_ready = 1'b1; s_rdata = 32'h0BAD_0BAD;                     // stray ready in IDLE
        tick();
        s_ready = 1'b0;
        tick();
        checks++;
        if (m0_ready !== 1'b0 || m1_ready !== 1'b0 || s_valid !== 1'b0 || m0_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL tmo_stray got m0r=%b m1r=%b sv=%b d=%h want 0 0 0 deadbeef", m0_ready, m1_ready, s_valid, m0_rdata);
        end
    endtask

    // Slave answers in the very cycle the timeout would fire: answer wins.
    task automatic test_ready_at_limit();
        m1_addr = 32'h4000_3000; m1_valid = 1'b1;
        tick();                                                      // cycle 1
        for (int c = 2; c <= 16; c++) tick();                        // cycle 16
        s_ready = 1'b1; s_rdata = 32'h600D_F00D;
        tick();                                                      // cycle 17
        s_ready = 1'b0;
        checks++;
        if (m1_ready !== 1'b1 || err !== 1'b0 || m1_rdata !== 32'h600D_F00D) begin
            errors++; $display("FAIL limit_done got rdy=%b err=%b d=%h want 1 0 600df00d", m1_ready, err, m1_rdata);
        end
        m1_valid = 1'b0;
        tick();
        checks++;
        if (err_cnt !== 8'd1) begin
            errors++; $display("FAIL limit_cnt got=%0d want=1", err_cnt);
        end
    endtask

    // Asynchronous reset during ISSUE, then a tie that m0 must win.
    task automatic test_reset_mid();
        logic stray = 1'b0;
        m1_addr = 32'h4000_3004; m1_valid = 1'b1;
        tick(); tick();                                              // ISSUE
        #3 rst = 1'b0;
        #1;
        checks++;
        if (s_valid !== 1'b0 || m1_ready !== 1'b0 || m0_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_async got sv=%b m0r=%b m1r=%b want 0 0 0", s_valid, m0_ready, m1_ready);
        end
        tick(); tick();
        rst = 1'b1;
        m0_addr = 32'h4000_0040; m0_valid = 1'b1;
        tick();                                                      // ISSUE of new grant
        if (m0_ready !== 1'b0 || m1_ready !== 1'b0) stray = 1'b1;
        checks++;
        if (s_addr !== 32'h4000_0040 || s_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_tie got addr=%h v=%b want 40000040 1", s_addr, s_valid);
        end
        s_ready = 1'b1; s_rdata = 32'h0000_0777;
        tick();
        s_ready = 1'b0;
        checks++;
        if (stray || m0_ready !== 1'b1 || m1_ready !== 1'b0 || err_cnt !== 8'd0) begin
            errors++; $display("FAIL rstmid_done got stray=%b m0r=%b m1r=%b cnt=%0d want 0 1 0 0", stray, m0_ready, m1_ready, err_cnt);
        end
        m0_valid = 1'b0; m1_valid = 1'b0;
        tick();
    endtask

    // 300 back-to-back timeouts from m0: err_cnt must stick at 255.
    task automatic test_saturate();
        int   pulses = 0;
        logic wrap   = 1'b0;
        logic [7:0] prev;
        prev = err_cnt;
        m0_addr = 32'h4000_4FFC; m0_valid = 1'b1;
        for (int c = 0; c < 6000 && pulses < 300; c++) begin
            tick();
            if (err === 1'b1) pulses++;
            if (err_cnt < prev) wrap = 1'b1;
            prev = err_cnt;
        end
        m0_valid = 1'b0;
        checks++;
        if (pulses != 300) begin
            errors++; $display("FAIL sat_pulses got=%0d want=300", pulses);
        end
        tick(); tick();
        checks++;
        if (err_cnt !== 8'd255 || wrap) begin
            errors++; $display("FAIL sat_cnt got=%0d wrap=%b want 255 0", err_cnt, wrap);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie_round_robin();
        test_no_preempt();
        test_timeout();
        test_ready_at_limit();
        test_reset_mid();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
